lsm_sequencer: RTL

- Parametrised multi-cycle sequencer for the multi-register transfer instructions: LM, SM, LA and SA.
- Sits beside the decode-stage controller. It takes over what the external comp/comp1 compare logic used to do.
- Each cycle it emits one register index and one data-memory address.
- It holds fetch (PC write) until the last transfer, then pulses done.
- Successor features:
  - width, depth and address step are generic;
  - LA/SA all-register mode is internal;
  - zero-mask skip;
  - flush abort;
  - R7-load redirect flag.

---
 rtl/lsm_sequencer_pkg.sv | 25 ++
 rtl/lsm_sequencer_if.sv | 37 +++
 rtl/lsm_sequencer_prio_enc.sv | 23 ++
 rtl/lsm_sequencer.sv | 101 ++++++++++
 4 files changed

// File: rtl/lsm_sequencer_pkg.sv
// Shared types for the multi-register transfer sequencer: instruction modes and FSM states.
package lsm_pkg;

  typedef enum logic [1:0] {
    MODE_LM = 2'b00,
    MODE_SM = 2'b01,
    MODE_LA = 2'b10,
    MODE_SA = 2'b11
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic is_load(input mode_e m);
    return (m == MODE_LM) || (m == MODE_LA);
  endfunction

  // LA/SA move every register, so the decoded mask is not used
  function automatic logic is_all_regs(input mode_e m);
    return (m == MODE_LA) || (m == MODE_SA);
  endfunction

endpackage

// File: rtl/lsm_sequencer_if.sv
// Decode-side request and memory-side transfer signals of the LM/SM/LA/SA sequencer.
interface lsm_sequencer_if #(
  parameter int DW   = 16,
  parameter int NREG = 8
);
  import lsm_pkg::*;

  localparam int RIDX_W = $clog2(NREG);

  logic              start;
  mode_e             mode;
  logic [DW-1:0]     base_addr;
  logic [NREG-1:0]   mask;
  logic              flush;
  logic              busy;
  logic              stall_fetch;
  logic              xfer_valid;
  logic [RIDX_W-1:0] xfer_reg;
  logic [DW-1:0]     xfer_addr;
  logic              xfer_read;
  logic              xfer_write;
  logic              xfer_pc;
  logic              done;

  modport master (
    output start, mode, base_addr, mask, flush,
    input  busy, stall_fetch, xfer_valid, xfer_reg, xfer_addr,
           xfer_read, xfer_write, xfer_pc, done
  );

  modport slave (
    input  start, mode, base_addr, mask, flush,
    output busy, stall_fetch, xfer_valid, xfer_reg, xfer_addr,
           xfer_read, xfer_write, xfer_pc, done
  );

endinterface

// File: rtl/lsm_sequencer_prio_enc.sv
// Lowest-set-bit encoder over the remaining transfer mask, with any/single-bit flags.
module lsm_prio_enc #(
  parameter  int NREG   = 8,
  localparam int RIDX_W = $clog2(NREG)
) (
  input  logic [NREG-1:0]   mask,
  output logic [RIDX_W-1:0] low_idx,
  output logic              any_set,
  output logic              single
);

  always_comb begin
    low_idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (mask[i]) low_idx = RIDX_W'(i);
    end
  end

  // m & (m-1) drops the lowest set bit; empty result means one bit was set
  assign any_set = |mask;
  assign single  = any_set & ~(|(mask & (mask - NREG'(1))));

endmodule

// File: rtl/lsm_sequencer.sv
// Multi-cycle LM/SM/LA/SA sequencer: one register/address transfer per cycle, holds fetch
// until the last transfer. state | meaning: IDLE | waiting for start ; RUN | issuing transfers
module lsm_sequencer
  import lsm_pkg::*;
#(
  parameter int DW        = 16,
  parameter int NREG      = 8,
  parameter int ADDR_STEP = 1
) (
  input logic            clk,
  input logic            reset,
  lsm_sequencer_if.slave bus
);

  localparam int RIDX_W = $clog2(NREG);

  state_e            state_q, state_d;
  logic [NREG-1:0]   rem_q, rem_d;
  logic [DW-1:0]     addr_q, addr_d;
  mode_e             mode_q, mode_d;
  logic              done_q, done_d;

  logic [NREG-1:0]   eff_mask;
  logic [RIDX_W-1:0] low_idx;
  logic              any_set;
  logic              last;
  logic              req_ok;
  logic              run;

  lsm_prio_enc #(.NREG(NREG)) u_prio_enc (
    .mask    (rem_q),
    .low_idx (low_idx),
    .any_set (any_set),
    .single  (last)
  );

  assign eff_mask = is_all_regs(bus.mode) ? '1 : bus.mask;
  assign req_ok   = (state_q == IDLE) & bus.start & ~bus.flush;
  assign run      = (state_q == RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      addr_q  <= '0;
      mode_q  <= MODE_LM;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_ok && (|eff_mask)) begin
          state_d = RUN;
          rem_d   = eff_mask;
          addr_d  = bus.base_addr;
          mode_d  = bus.mode;
        end else if (req_ok) begin
          // empty LM/SM mask: nothing to move, just acknowledge next cycle
          done_d = 1'b1;
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_d = IDLE;
          rem_d   = '0;
        end else begin
          rem_d  = rem_q & ~(NREG'(1) << low_idx);
          addr_d = addr_q + DW'(ADDR_STEP);
          if (last || !any_set) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy        = run;
    bus.stall_fetch = (req_ok & (|eff_mask)) | (run & ~last);
    bus.xfer_valid  = run & ~bus.flush;
    bus.xfer_reg    = low_idx;
    bus.xfer_addr   = run ? addr_q : '0;
    bus.xfer_read   = bus.xfer_valid & is_load(mode_q);
    bus.xfer_write  = bus.xfer_valid & ~is_load(mode_q);
    bus.xfer_pc     = bus.xfer_read & (low_idx == RIDX_W'(NREG - 1));
    bus.done        = done_q | (run & last & ~bus.flush);
  end

endmodule
